// File: rtl/data_receiver_fsm.sv
// Receive-side link controller: arms the serial receiver and watches for stalled packets.
// It qualifies each completed packet by CRC and 1-bit sequence number, and drives the ACK handshake.
module data_receiver_fsm #(
    parameter int unsigned RECV_TIMEOUT = 2048,
    parameter int unsigned ERR_CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 game_active,
    input  logic                 pkt_start,
    input  logic                 recv_done,
    input  logic                 crc_ok,
    input  logic                 recv_seq,
    input  logic                 ack_done,
    output logic                 recv_en,
    output logic                 ack_start,
    output logic                 ack_seq,
    output logic                 data_valid,
    output logic                 recv_abort,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int unsigned WD_W = (RECV_TIMEOUT > 2) ? $clog2(RECV_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(RECV_TIMEOUT - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LISTEN = 3'd1,
        RECV   = 3'd2,
        CHECK  = 3'd3,
        ACK    = 3'd4
    } state_t;

    state_t          state;
    logic [WD_W-1:0] watchdog;
    logic            expected_seq;
    logic            crc_lat;
    logic            seq_lat;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == ERR_MAX) ? v : v + ERR_CNT_W'(1);
    endfunction

    // Single-process FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            watchdog     <= '0;
            expected_seq <= 1'b0;
            crc_lat      <= 1'b0;
            seq_lat      <= 1'b0;
            recv_en      <= 1'b0;
            ack_start    <= 1'b0;
            ack_seq      <= 1'b0;
            data_valid   <= 1'b0;
            recv_abort   <= 1'b0;
            err_cnt      <= '0;
        end else begin
            ack_start  <= 1'b0;
            data_valid <= 1'b0;
            recv_abort <= 1'b0;

            if (state != IDLE && !game_active) begin
                state        <= IDLE;
                recv_en      <= 1'b0;
                expected_seq <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (game_active) begin
                            state   <= LISTEN;
                            recv_en <= 1'b1;
                        end
                    end

                    LISTEN: begin
                        if (pkt_start) begin
                            state    <= RECV;
                            watchdog <= '0;
                        end
                    end

                    // recv_done outranks a watchdog expiry in the same cycle.
                    RECV: begin
                        watchdog <= watchdog + WD_W'(1);
                        if (recv_done) begin
                            state   <= CHECK;
                            recv_en <= 1'b0;
                            crc_lat <= crc_ok;
                            seq_lat <= recv_seq;
                        end else if (watchdog == WD_LAST) begin
                            state      <= LISTEN;
                            recv_abort <= 1'b1;
                            err_cnt    <= sat_inc(err_cnt);
                        end
                    end

                    // A duplicate (lost ACK) is re-ACKed but not delivered again.
                    CHECK: begin
                        if (!crc_lat) begin
                            state   <= LISTEN;
                            recv_en <= 1'b1;
                            err_cnt <= sat_inc(err_cnt);
                        end else begin
                            state     <= ACK;
                            ack_start <= 1'b1;
                            ack_seq   <= seq_lat;
                            if (seq_lat == expected_seq) begin
                                data_valid   <= 1'b1;
                                expected_seq <= ~expected_seq;
                            end
                        end
                    end

                    // ack_start is high only in the first ACK cycle, where ack_done is ignored.
                    ACK: begin
                        if (ack_done && !ack_start) begin
                            state   <= LISTEN;
                            recv_en <= 1'b1;
                        end
                    end

                    default: begin
                        state   <= IDLE;
                        recv_en <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_data_receiver_fsm.sv
// Directed bench for data_receiver_fsm: a packet table plus hand sequences for the timeout, game-drop, reset and saturation cases.
module tb_data_receiver_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       game_active;
    logic       pkt_start;
    logic       recv_done;
    logic       crc_ok;
    logic       recv_seq;
    logic       ack_done;
    logic       recv_en;
    logic       ack_start;
    logic       ack_seq;
    logic       data_valid;
    logic       recv_abort;
    logic [7:0] err_cnt;

    int n_total  = 0;
    int n_passed = 0;
    int exp_err  = 0;

    typedef struct {
        logic crc;
        logic seq;
        int   dly;
        logic exp_dv;
        logic exp_ack;
    } vec_t;

    vec_t vecs[7];

    data_receiver_fsm #(.RECV_TIMEOUT(16), .ERR_CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .game_active(game_active),
        .pkt_start  (pkt_start),
        .recv_done  (recv_done),
        .crc_ok     (crc_ok),
        .recv_seq   (recv_seq),
        .ack_done   (ack_done),
        .recv_en    (recv_en),
        .ack_start  (ack_start),
        .ack_seq    (ack_seq),
        .data_valid (data_valid),
        .recv_abort (recv_abort),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        else
            n_passed++;
    endtask

    function automatic int sat(input int v);
        return (v < 255) ? v + 1 : v;
    endfunction

    // Starts from LISTEN, spends dly extra cycles in RECV, then completes the handshake.
    task automatic run_pkt(input logic crc, input logic seq, input int dly,
                           input logic exp_dv, input logic exp_ack, input string nm);
        pkt_start = 1'b1;
        tick();
        pkt_start = 1'b0;
        check({nm, ".recv_en_recv"}, int'(recv_en), 1);
        repeat (dly) tick();
        recv_done = 1'b1; crc_ok = crc; recv_seq = seq;
        tick();
        recv_done = 1'b0; crc_ok = 1'b0; recv_seq = 1'b0;
        check({nm, ".recv_en_check"}, int'(recv_en), 0);
        check({nm, ".abort_check"}, int'(recv_abort), 0);
        check({nm, ".ack_early"}, int'(ack_start), 0);
        tick();
        if (!crc) exp_err = sat(exp_err);
        check({nm, ".ack_start"}, int'(ack_start), int'(exp_ack));
        check({nm, ".data_valid"}, int'(data_valid), int'(exp_dv));
        check({nm, ".err_cnt"}, int'(err_cnt), exp_err);
        if (exp_ack) begin
            check({nm, ".ack_seq"}, int'(ack_seq), int'(seq));
            repeat (5) tick();
            check({nm, ".ack_pulse_end"}, int'(ack_start), 0);
            check({nm, ".recv_en_ack"}, int'(recv_en), 0);
            check({nm, ".ack_seq_hold"}, int'(ack_seq), int'(seq));
            ack_done = 1'b1;
            tick();
            ack_done = 1'b0;
        end
        check({nm, ".recv_en_listen"}, int'(recv_en), 1);
    endtask

    initial begin
        vecs[0] = '{crc: 1'b1, seq: 1'b0, dly: 10, exp_dv: 1'b1, exp_ack: 1'b1};
        vecs[1] = '{crc: 1'b1, seq: 1'b0, dly: 10, exp_dv: 1'b0, exp_ack: 1'b1};
        vecs[2] = '{crc: 1'b1, seq: 1'b1, dly: 3,  exp_dv: 1'b1, exp_ack: 1'b1};
        vecs[3] = '{crc: 1'b0, seq: 1'b0, dly: 5,  exp_dv: 1'b0, exp_ack: 1'b0};
        vecs[4] = '{crc: 1'b1, seq: 1'b0, dly: 15, exp_dv: 1'b1, exp_ack: 1'b1};
        vecs[5] = '{crc: 1'b1, seq: 1'b1, dly: 0,  exp_dv: 1'b1, exp_ack: 1'b1};
        vecs[6] = '{crc: 1'b1, seq: 1'b1, dly: 2,  exp_dv: 1'b0, exp_ack: 1'b1};

        rst = 1'b1; game_active = 1'b0; pkt_start = 1'b0; recv_done = 1'b0;
        crc_ok = 1'b0; recv_seq = 1'b0; ack_done = 1'b0;
        #2;
        check("rst.recv_en", int'(recv_en), 0);
        check("rst.ack_start", int'(ack_start), 0);
        check("rst.data_valid", int'(data_valid), 0);
        check("rst.recv_abort", int'(recv_abort), 0);
        check("rst.err_cnt", int'(err_cnt), 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("idle.recv_en", int'(recv_en), 0);
        game_active = 1'b1;
        tick();
        check("listen.recv_en", int'(recv_en), 1);

        for (int i = 0; i < 7; i++)
            run_pkt(vecs[i].crc, vecs[i].seq, vecs[i].dly, vecs[i].exp_dv, vecs[i].exp_ack,
                    $sformatf("vec%0d", i));

        // Watchdog expiry: 16 RECV cycles without recv_done.
        pkt_start = 1'b1;
        tick();
        pkt_start = 1'b0;
        repeat (15) tick();
        check("wd.no_abort_yet", int'(recv_abort), 0);
        check("wd.still_recv", int'(recv_en), 1);
        tick();
        exp_err = sat(exp_err);
        check("wd.abort", int'(recv_abort), 1);
        check("wd.err_cnt", int'(err_cnt), exp_err);
        check("wd.listen", int'(recv_en), 1);
        tick();
        check("wd.abort_pulse", int'(recv_abort), 0);

        // ack_done held from the first ACK cycle only counts from the second.
        pkt_start = 1'b1;
        tick();
        pkt_start = 1'b0;
        recv_done = 1'b1; crc_ok = 1'b1; recv_seq = 1'b0;
        tick();
        recv_done = 1'b0; crc_ok = 1'b0;
        tick();
        check("ackfirst.dv", int'(data_valid), 1);
        ack_done = 1'b1;
        tick();
        check("ackfirst.stay_ack", int'(recv_en), 0);
        tick();
        ack_done = 1'b0;
        check("ackfirst.listen", int'(recv_en), 1);

        // game_active dropped in RECV clears expected_seq (it was 1 here).
        pkt_start = 1'b1;
        tick();
        pkt_start = 1'b0;
        game_active = 1'b0;
        tick();
        check("drop_recv.idle", int'(recv_en), 0);
        game_active = 1'b1;
        tick();
        check("drop_recv.listen", int'(recv_en), 1);
        run_pkt(1'b1, 1'b0, 2, 1'b1, 1'b1, "drop_recv.pkt");

        // game_active dropped in ACK.
        pkt_start = 1'b1;
        tick();
        pkt_start = 1'b0;
        recv_done = 1'b1; crc_ok = 1'b1; recv_seq = 1'b1;
        tick();
        recv_done = 1'b0; crc_ok = 1'b0; recv_seq = 1'b0;
        tick();
        check("drop_ack.ack_start", int'(ack_start), 1);
        game_active = 1'b0;
        tick();
        check("drop_ack.idle", int'(recv_en), 0);
        check("drop_ack.no_pulse", int'(ack_start), 0);
        game_active = 1'b1;
        tick();
        run_pkt(1'b1, 1'b0, 4, 1'b1, 1'b1, "drop_ack.pkt");

        // Asynchronous reset while in CHECK.
        pkt_start = 1'b1;
        tick();
        pkt_start = 1'b0;
        recv_done = 1'b1; crc_ok = 1'b1; recv_seq = 1'b1;
        tick();
        recv_done = 1'b0; crc_ok = 1'b0; recv_seq = 1'b0;
        #2 rst = 1'b1;
        #1;
        exp_err = 0;
        check("arst.recv_en", int'(recv_en), 0);
        check("arst.err_cnt", int'(err_cnt), 0);
        check("arst.ack_start", int'(ack_start), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("arst.no_ack", int'(ack_start), 0);
        check("arst.no_dv", int'(data_valid), 0);
        check("arst.listen", int'(recv_en), 1);
        run_pkt(1'b1, 1'b0, 1, 1'b1, 1'b1, "arst.pkt");

        // 300 CRC failures saturate the 8-bit counter.
        for (int i = 0; i < 300; i++) begin
            pkt_start = 1'b1;
            tick();
            pkt_start = 1'b0;
            recv_done = 1'b1; crc_ok = 1'b0;
            tick();
            recv_done = 1'b0;
            tick();
            exp_err = sat(exp_err);
            if (i == 254) check("sat.reach_255", int'(err_cnt), exp_err);
        end
        check("sat.err_cnt", int'(err_cnt), exp_err);
        check("sat.value", int'(err_cnt), 255);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
